// File: rtl/gumnut_control_unit.sv
// Gumnut instruction sequencer: owns the PC, return stack and interrupt enable, and
// runs the fetch/decode/execute/mem/write FSM driving datapath strobes and bus handshakes.
module gumnut_control_unit #(
    parameter int unsigned RSTACK_DEPTH = 8,
    parameter logic [11:0] INT_VECTOR   = 12'h001,
    parameter logic [11:0] RESET_PC     = 12'h000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  op_e,
    input  logic [2:0]  func_e,
    input  logic [11:0] addr_e,
    input  logic [7:0]  disp_e,
    input  logic        ccC_e,
    input  logic        ccZ_e,
    input  logic        inst_ack_i,
    input  logic        data_ack_i,
    input  logic        port_ack_i,
    input  logic        int_req_i,
    output logic        ClkEn_e,
    output logic        RegWrt_c,
    output logic [1:0]  RegMux_c,
    output logic        DPMux_c,
    output logic        op2_c,
    output logic [3:0]  ALUOp_c,
    output logic        ALUEn_c,
    output logic        ALUFR_c,
    output logic        port_we_c,
    output logic        reti_c,
    output logic        intc_o,
    output logic        intz_o,
    output logic        inst_cyc_o,
    output logic        inst_stb_o,
    output logic [11:0] inst_adr_o,
    output logic        data_cyc_o,
    output logic        data_stb_o,
    output logic        data_we_o,
    output logic        port_cyc_o,
    output logic        port_stb_o,
    output logic        int_ack_o
);
    // state   | meaning
    // FETCH   | instruction bus cycle at PC, wait for ack
    // DECODE  | register read
    // EXECUTE | ALU op, address calc, branch/jump/misc
    // MEM     | data or port bus cycle, wait for ack
    // WRITE   | register write-back
    // END     | interrupt check
    // INT     | interrupt entry: push PC, save flags, vector
    // HALT    | wait/stby, datapath clock gated
    localparam int unsigned SPW = $clog2(RSTACK_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITE, S_END, S_INT, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     pc_q, pc_d;
    logic [SPW-1:0]  sp_q, sp_d, sp_m1;
    logic [11:0]     rstack_q [RSTACK_DEPTH];
    logic            int_en_q, int_en_d;
    logic            halt_wait_q, halt_wait_d;
    logic            intc_q, intz_q, mem_first_q;
    logic            push;

    logic is_alu_imm, is_alu_reg, is_shift, is_mem, is_branch, is_jump, is_misc;
    logic is_ldm, is_stm, is_inp, is_out, taken;

    assign is_alu_imm = ~op_e[6];
    assign is_alu_reg = (op_e[6:3] == 4'b1110);
    assign is_shift   = (op_e[6:4] == 3'b110);
    assign is_mem     = (op_e[6:5] == 2'b10);
    assign is_branch  = (op_e[6:1] == 6'b111110);
    assign is_jump    = (op_e[6:2] == 5'b11110);
    assign is_misc    = (op_e == 7'b1111110);
    assign is_ldm     = is_mem && (op_e[4:3] == 2'b00);
    assign is_stm     = is_mem && (op_e[4:3] == 2'b01);
    assign is_inp     = is_mem && (op_e[4:3] == 2'b10);
    assign is_out     = is_mem && (op_e[4:3] == 2'b11);
    assign sp_m1      = sp_q - SPW'(1);

    always_comb begin
        unique case (func_e[1:0])
            2'b00:   taken = ccZ_e;
            2'b01:   taken = ~ccZ_e;
            2'b10:   taken = ccC_e;
            default: taken = ~ccC_e;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        int_en_d    = int_en_q;
        halt_wait_d = halt_wait_q;
        push        = 1'b0;
        ClkEn_e     = 1'b1;
        RegWrt_c    = 1'b0;
        RegMux_c    = 2'b00;
        DPMux_c     = 1'b0;
        op2_c       = 1'b0;
        ALUOp_c     = 4'b0000;
        ALUEn_c     = 1'b0;
        ALUFR_c     = 1'b0;
        port_we_c   = 1'b0;
        reti_c      = 1'b0;
        inst_cyc_o  = 1'b0;
        inst_stb_o  = 1'b0;
        data_cyc_o  = 1'b0;
        data_stb_o  = 1'b0;
        data_we_o   = 1'b0;
        port_cyc_o  = 1'b0;
        port_stb_o  = 1'b0;
        int_ack_o   = 1'b0;

        case (state_q)
            S_FETCH: begin
                inst_cyc_o = 1'b1;
                inst_stb_o = 1'b1;
                if (inst_ack_i) begin
                    pc_d    = pc_q + 12'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                state_d = S_END;
                if (is_alu_imm || is_alu_reg) begin
                    ALUOp_c = {1'b0, func_e};
                    ALUEn_c = 1'b1;
                    ALUFR_c = 1'b1;
                    op2_c   = is_alu_imm;
                    state_d = S_WRITE;
                end else if (is_shift) begin
                    ALUOp_c = {2'b10, func_e[1:0]};
                    ALUEn_c = 1'b1;
                    ALUFR_c = 1'b1;
                    state_d = S_WRITE;
                end else if (is_mem) begin
                    ALUOp_c = 4'b1100;
                    op2_c   = 1'b1;
                    DPMux_c = is_stm || is_out;
                    state_d = S_MEM;
                end else if (is_branch) begin
                    if (taken) pc_d = pc_q + {{4{disp_e[7]}}, disp_e};
                end else if (is_jump) begin
                    push = op_e[1];
                    pc_d = addr_e;
                end else if (is_misc) begin
                    case (func_e)
                        3'b000: begin
                            pc_d = rstack_q[sp_m1];
                            sp_d = sp_m1;
                        end
                        3'b001: begin
                            pc_d     = rstack_q[sp_m1];
                            sp_d     = sp_m1;
                            reti_c   = 1'b1;
                            int_en_d = 1'b1;
                        end
                        3'b010: int_en_d = 1'b1;
                        3'b011: int_en_d = 1'b0;
                        3'b100: begin
                            halt_wait_d = 1'b1;
                            state_d     = S_HALT;
                        end
                        3'b101: begin
                            halt_wait_d = 1'b0;
                            state_d     = S_HALT;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                if (is_ldm || is_stm) begin
                    data_cyc_o = 1'b1;
                    data_stb_o = 1'b1;
                    data_we_o  = is_stm;
                    if (data_ack_i) state_d = is_ldm ? S_WRITE : S_END;
                end else begin
                    port_cyc_o = 1'b1;
                    port_stb_o = 1'b1;
                    port_we_c  = is_out && mem_first_q;
                    if (port_ack_i) state_d = is_inp ? S_WRITE : S_END;
                end
            end
            S_WRITE: begin
                RegWrt_c = 1'b1;
                RegMux_c = is_ldm ? 2'b01 : (is_inp ? 2'b10 : 2'b00);
                state_d  = S_END;
            end
            S_END: state_d = (int_en_q && int_req_i) ? S_INT : S_FETCH;
            S_INT: begin
                push      = 1'b1;
                pc_d      = INT_VECTOR;
                int_en_d  = 1'b0;
                int_ack_o = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                ClkEn_e = 1'b0;
                if (halt_wait_q && int_en_q && int_req_i) state_d = S_INT;
            end
            default: state_d = S_FETCH;
        endcase

        if (push) sp_d = sp_q + SPW'(1);

        // Reset is synchronous, so bus requests must be masked while it is held.
        if (rst_i) begin
            inst_cyc_o = 1'b0;
            inst_stb_o = 1'b0;
            data_cyc_o = 1'b0;
            data_stb_o = 1'b0;
            data_we_o  = 1'b0;
            port_cyc_o = 1'b0;
            port_stb_o = 1'b0;
            port_we_c  = 1'b0;
            RegWrt_c   = 1'b0;
            ALUEn_c    = 1'b0;
            ALUFR_c    = 1'b0;
            reti_c     = 1'b0;
            int_ack_o  = 1'b0;
            ClkEn_e    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            sp_q        <= '0;
            int_en_q    <= 1'b0;
            halt_wait_q <= 1'b0;
            intc_q      <= 1'b0;
            intz_q      <= 1'b0;
            mem_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            int_en_q    <= int_en_d;
            halt_wait_q <= halt_wait_d;
            mem_first_q <= (state_q == S_EXECUTE);
            if (state_q == S_INT) begin
                intc_q <= ccC_e;
                intz_q <= ccZ_e;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) rstack_q[sp_q] <= pc_q;
    end

    assign inst_adr_o = pc_q;
    assign intc_o     = intc_q;
    assign intz_o     = intz_q;
endmodule

// File: tb/tb_gumnut_control_unit.sv
// Directed bench for gumnut_control_unit: acts as instruction/data/port memory and
// checks cycle counts, strobes and PC flow against hand-computed vectors.
module tb_gumnut_control_unit;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [6:0]  op_e = '0;
    logic [2:0]  func_e = '0;
    logic [11:0] addr_e = '0;
    logic [7:0]  disp_e = '0;
    logic        ccC_e = 1'b0, ccZ_e = 1'b0;
    logic        inst_ack_i = 1'b0, data_ack_i = 1'b0, port_ack_i = 1'b0, int_req_i = 1'b0;
    logic        ClkEn_e, RegWrt_c, DPMux_c, op2_c, ALUEn_c, ALUFR_c, port_we_c, reti_c;
    logic [1:0]  RegMux_c;
    logic [3:0]  ALUOp_c;
    logic        intc_o, intz_o, inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o, data_we_o;
    logic        port_cyc_o, port_stb_o, int_ack_o;
    logic [11:0] inst_adr_o;

    gumnut_control_unit dut (
        .clk_i(clk), .rst_i(rst_i), .op_e(op_e), .func_e(func_e), .addr_e(addr_e),
        .disp_e(disp_e), .ccC_e(ccC_e), .ccZ_e(ccZ_e), .inst_ack_i(inst_ack_i),
        .data_ack_i(data_ack_i), .port_ack_i(port_ack_i), .int_req_i(int_req_i),
        .ClkEn_e(ClkEn_e), .RegWrt_c(RegWrt_c), .RegMux_c(RegMux_c), .DPMux_c(DPMux_c),
        .op2_c(op2_c), .ALUOp_c(ALUOp_c), .ALUEn_c(ALUEn_c), .ALUFR_c(ALUFR_c),
        .port_we_c(port_we_c), .reti_c(reti_c), .intc_o(intc_o), .intz_o(intz_o),
        .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .inst_adr_o(inst_adr_o),
        .data_cyc_o(data_cyc_o), .data_stb_o(data_stb_o), .data_we_o(data_we_o),
        .port_cyc_o(port_cyc_o), .port_stb_o(port_stb_o), .int_ack_o(int_ack_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f;
        logic [11:0] a;
        logic [7:0]  d;
        logic        c, z;
        logic [11:0] npc;
        int          cyc, rw, rw_at;
        logic [1:0]  rm;
        logic [3:0]  aop;
        logic        o2, dp;
        int          aen_at, dwe, pwe;
    } vec_t;

    vec_t        tbl [16];
    int          n_vec = 0, n_bad = 0;
    logic [11:0] exp_pc = 12'h000;
    int          data_wait = 0, port_wait = 0;
    int          o_cyc, o_rw, o_rw_at, o_aen_at, o_dwe, o_pwe, o_dstb, o_pstb, o_iack, o_reti;
    int          o_clken_low, excl_viol = 0;
    logic [1:0]  o_rm;
    logic [3:0]  o_aop;
    logic        o_o2, o_dp;
    logic [11:0] pushed [1:9];

    function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f, input logic [11:0] a,
                                input logic [7:0] d, input logic c, input logic z,
                                input logic [11:0] npc, input int cyc, input int rw,
                                input int rw_at, input logic [1:0] rm, input logic [3:0] aop,
                                input logic o2, input logic dp, input int aen_at,
                                input int dwe, input int pwe);
        vec_t v;
        v.op = op; v.f = f; v.a = a; v.d = d; v.c = c; v.z = z; v.npc = npc;
        v.cyc = cyc; v.rw = rw; v.rw_at = rw_at; v.rm = rm; v.aop = aop;
        v.o2 = o2; v.dp = dp; v.aen_at = aen_at; v.dwe = dwe; v.pwe = pwe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; waits for the fetch, checks its address, acks and loads the IR fields.
    task automatic fetch_instr(input string tag, input logic [6:0] op, input logic [2:0] f,
                               input logic [11:0] a, input logic [7:0] d,
                               input logic c, input logic z);
        int n = 0;
        while (!inst_cyc_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " fetch_seen"}, 32'(inst_cyc_o), 32'd1);
        check({tag, " inst_adr"}, 32'(inst_adr_o), 32'(exp_pc));
        inst_ack_i = 1'b1;
        @(posedge clk);
        #1;
        inst_ack_i = 1'b0;
        op_e = op; func_e = f; addr_e = a; disp_e = d; ccC_e = c; ccZ_e = z;
    endtask

    task automatic run_to_next(input string tag);
        int dcnt = 0, pcnt = 0;
        bit done = 0;
        o_cyc = 1; o_rw = 0; o_rw_at = 0; o_aen_at = 0; o_dwe = 0; o_pwe = 0; o_dstb = 0;
        o_pstb = 0; o_iack = 0; o_reti = 0; o_clken_low = 0; o_rm = 2'b00; o_aop = 4'h0;
        o_o2 = 1'b0; o_dp = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            data_ack_i = 1'b0;
            port_ack_i = 1'b0;
            if (int'(inst_cyc_o) + int'(data_cyc_o) + int'(port_cyc_o) > 1) excl_viol++;
            if (inst_cyc_o) begin
                done = 1;
                break;
            end
            o_cyc++;
            if (!ClkEn_e) o_clken_low++;
            if (RegWrt_c) begin
                o_rw++;
                o_rw_at = o_cyc;
                o_rm = RegMux_c;
            end
            if (ALUEn_c) o_aen_at = o_cyc;
            if (o_cyc == 3) begin
                o_aop = ALUOp_c;
                o_o2 = op2_c;
                o_dp = DPMux_c;
            end
            if (reti_c) o_reti++;
            if (int_ack_o) begin
                o_iack++;
                int_req_i = 1'b0;
            end
            if (port_we_c) o_pwe++;
            if (data_stb_o) begin
                o_dstb++;
                if (data_we_o) o_dwe++;
                if (dcnt == data_wait) data_ack_i = 1'b1;
                dcnt++;
            end
            if (port_stb_o) begin
                o_pstb++;
                if (pcnt == port_wait) port_ack_i = 1'b1;
                pcnt++;
            end
        end
        if (!done) check({tag, " next_fetch_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic exec(input string tag, input logic [6:0] op, input logic [2:0] f,
                        input logic [11:0] a, input logic [7:0] d, input logic c, input logic z);
        fetch_instr(tag, op, f, a, d, c, z);
        run_to_next(tag);
    endtask

    initial begin
        int halt_bad;
        logic [11:0] tgt;
        // op       f       addr     disp   c  z  npc      cyc rw at rm     aop      o2 dp aen dwe pwe
        tbl[0]  = mk(7'h00, 3'b000, 12'h000, 8'h00, 0, 0, 12'h001, 5, 1, 4, 2'b00, 4'b0000, 1, 0, 3, 0, 0);
        tbl[1]  = mk(7'h70, 3'b011, 12'h000, 8'h00, 0, 0, 12'h002, 5, 1, 4, 2'b00, 4'b0011, 0, 0, 3, 0, 0);
        tbl[2]  = mk(7'h60, 3'b110, 12'h000, 8'h00, 0, 0, 12'h003, 5, 1, 4, 2'b00, 4'b1010, 0, 0, 3, 0, 0);
        tbl[3]  = mk(7'h40, 3'b000, 12'h000, 8'h00, 0, 0, 12'h004, 6, 1, 5, 2'b01, 4'b1100, 1, 0, 0, 0, 0);
        tbl[4]  = mk(7'h48, 3'b000, 12'h000, 8'h00, 0, 0, 12'h005, 5, 0, 0, 2'b00, 4'b1100, 1, 1, 0, 1, 0);
        tbl[5]  = mk(7'h50, 3'b000, 12'h000, 8'h00, 0, 0, 12'h006, 6, 1, 5, 2'b10, 4'b1100, 1, 0, 0, 0, 0);
        tbl[6]  = mk(7'h58, 3'b000, 12'h000, 8'h00, 0, 0, 12'h007, 5, 0, 0, 2'b00, 4'b1100, 1, 1, 0, 0, 1);
        tbl[7]  = mk(7'h78, 3'b000, 12'h010, 8'h00, 0, 0, 12'h010, 4, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tbl[8]  = mk(7'h7C, 3'b000, 12'h000, 8'hFE, 0, 1, 12'h00F, 4, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tbl[9]  = mk(7'h7C, 3'b000, 12'h000, 8'hFE, 0, 0, 12'h010, 4, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tbl[10] = mk(7'h7C, 3'b001, 12'h000, 8'h05, 0, 0, 12'h016, 4, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tbl[11] = mk(7'h7D, 3'b010, 12'h000, 8'h05, 0, 0, 12'h017, 4, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tbl[12] = mk(7'h7D, 3'b011, 12'h000, 8'h80, 0, 0, 12'hF98, 4, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tbl[13] = mk(7'h7F, 3'b000, 12'h000, 8'h00, 0, 0, 12'hF99, 4, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tbl[14] = mk(7'h78, 3'b000, 12'hFFF, 8'h00, 0, 0, 12'hFFF, 4, 0, 0, 2'b00, 4'b0000, 0, 0, 0, 0, 0);
        tbl[15] = mk(7'h3D, 3'b101, 12'h000, 8'h00, 0, 0, 12'h000, 5, 1, 4, 2'b00, 4'b0101, 1, 0, 3, 0, 0);

        // Reset state, then a reset landing mid-fetch must drop cyc/stb immediately.
        repeat (3) @(negedge clk);
        check("rst inst_cyc", 32'(inst_cyc_o), 32'd0);
        check("rst ClkEn", 32'(ClkEn_e), 32'd1);
        check("rst strobes", 32'({RegWrt_c, ALUEn_c, data_cyc_o, port_cyc_o, int_ack_o, port_we_c}), 32'd0);
        check("rst intcz", 32'({intc_o, intz_o}), 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        check("post-rst fetch", 32'({inst_cyc_o, inst_stb_o}), 32'h3);
        check("post-rst adr", 32'(inst_adr_o), 32'h000);
        rst_i = 1'b1;
        #1;
        check("midcycle rst drops cyc", 32'({inst_cyc_o, inst_stb_o}), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            exec(t, tbl[i].op, tbl[i].f, tbl[i].a, tbl[i].d, tbl[i].c, tbl[i].z);
            check({t, " cycles"}, 32'(o_cyc), 32'(tbl[i].cyc));
            check({t, " regwrt"}, 32'(o_rw), 32'(tbl[i].rw));
            check({t, " regwrt_at"}, 32'(o_rw_at), 32'(tbl[i].rw_at));
            check({t, " regmux"}, 32'(o_rm), 32'(tbl[i].rm));
            check({t, " aluop"}, 32'(o_aop), 32'(tbl[i].aop));
            check({t, " op2"}, 32'(o_o2), 32'(tbl[i].o2));
            check({t, " dpmux"}, 32'(o_dp), 32'(tbl[i].dp));
            check({t, " aluen_at"}, 32'(o_aen_at), 32'(tbl[i].aen_at));
            check({t, " data_we"}, 32'(o_dwe), 32'(tbl[i].dwe));
            check({t, " port_we"}, 32'(o_pwe), 32'(tbl[i].pwe));
            exp_pc = tbl[i].npc;
        end

        // ldm with a 3-cycle data wait.
        data_wait = 3;
        exec("ldm_wait", 7'h40, 3'b000, 12'h000, 8'h00, 1'b0, 1'b0);
        data_wait = 0;
        check("ldm_wait cycles", 32'(o_cyc), 32'd9);
        check("ldm_wait stb_cycles", 32'(o_dstb), 32'd4);
        check("ldm_wait data_we", 32'(o_dwe), 32'd0);
        check("ldm_wait regwrt", 32'(o_rw), 32'd1);
        check("ldm_wait regmux", 32'(o_rm), 32'h1);
        check("ldm_wait clken_low", 32'(o_clken_low), 32'd0);
        exp_pc = 12'h001;

        // Nine nested jsb overflow the 8-entry stack; nine ret then unwind through the wrap.
        for (int m = 1; m <= 9; m++) begin
            pushed[m] = exp_pc + 12'd1;
            tgt = 12'h200 + 12'(16 * m);
            exec($sformatf("jsb%0d", m), 7'h7A, 3'b000, tgt, 8'h00, 1'b0, 1'b0);
            check($sformatf("jsb%0d cycles", m), 32'(o_cyc), 32'd4);
            exp_pc = tgt;
        end
        for (int k = 1; k <= 9; k++) begin
            exec($sformatf("ret%0d", k), 7'h7E, 3'b000, 12'h000, 8'h00, 1'b0, 1'b0);
            exp_pc = (k == 1 || k == 9) ? pushed[9] : pushed[10 - k];
        end

        // enai, then an interrupt request raised during ldm.
        exec("enai", 7'h7E, 3'b010, 12'h000, 8'h00, 1'b0, 1'b0);
        exp_pc = exp_pc + 12'd1;
        int_req_i = 1'b1;
        exec("ldm_int", 7'h40, 3'b000, 12'h000, 8'h00, 1'b1, 1'b0);
        check("ldm_int regwrt", 32'(o_rw), 32'd1);
        check("ldm_int cycles", 32'(o_cyc), 32'd7);
        check("int_ack pulses", 32'(o_iack), 32'd1);
        check("intc saved", 32'(intc_o), 32'd1);
        check("intz saved", 32'(intz_o), 32'd0);
        pushed[1] = exp_pc + 12'd1;
        exp_pc = 12'h001;
        exec("reti", 7'h7E, 3'b001, 12'h000, 8'h00, 1'b0, 1'b0);
        check("reti pulse", 32'(o_reti), 32'd1);
        exp_pc = pushed[1];

        exec("disi", 7'h7E, 3'b011, 12'h000, 8'h00, 1'b0, 1'b0);
        exp_pc = exp_pc + 12'd1;
        port_wait = 2;
        exec("out_wait", 7'h58, 3'b000, 12'h000, 8'h00, 1'b0, 1'b0);
        port_wait = 0;
        check("out port_we single", 32'(o_pwe), 32'd1);
        check("out port_stb cycles", 32'(o_pstb), 32'd3);
        check("out cycles", 32'(o_cyc), 32'd7);
        exp_pc = exp_pc + 12'd1;

        // wait with interrupts disabled: stays halted until reset.
        int_req_i = 1'b1;
        fetch_instr("wait", 7'h7E, 3'b100, 12'h000, 8'h00, 1'b0, 1'b0);
        halt_bad = 0;
        for (int c = 2; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 4 && (ClkEn_e || inst_cyc_o || data_cyc_o || port_cyc_o || int_ack_o))
                halt_bad++;
        end
        check("halt persists", 32'(halt_bad), 32'd0);
        check("halt ClkEn", 32'(ClkEn_e), 32'd0);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        int_req_i = 1'b0;
        check("after rst intcz", 32'({intc_o, intz_o}), 32'd0);
        exp_pc = 12'h000;
        exec("post-halt alu", 7'h00, 3'b000, 12'h000, 8'h00, 1'b0, 1'b0);
        check("post-halt cycles", 32'(o_cyc), 32'd5);
        check("post-halt next adr", 32'(inst_adr_o), 32'h001);
        check("bus exclusivity", 32'(excl_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
